// File: rtl/vector_exec_stage_if.sv
// Handshake and data bundle for the vector execute stage.
// The upstream side drives operands and the downstream side drives out_ready.
interface vector_exec_stage_if #(
  parameter int LANES  = 3,
  parameter int LANE_W = 16,
  parameter int TAG_W  = 5
);
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [4:0]              alu_ctrl;
  logic [LANES*LANE_W-1:0] src_a;
  logic [LANES*LANE_W-1:0] src_b;
  logic [TAG_W-1:0]        tag_in;
  logic                    we_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*LANE_W-1:0] result;
  logic [TAG_W-1:0]        tag_out;
  logic                    we_out;
  logic                    illegal_op;

  modport master (
    output flush, in_valid, alu_ctrl, src_a, src_b, tag_in, we_in, out_ready,
    input  in_ready, out_valid, result, tag_out, we_out, illegal_op
  );

  modport slave (
    input  flush, in_valid, alu_ctrl, src_a, src_b, tag_in, we_in, out_ready,
    output in_ready, out_valid, result, tag_out, we_out, illegal_op
  );
endinterface

// File: rtl/vector_exec_stage.sv
// SIMD execute stage: per-lane ALU with a multi-cycle multiply, valid/ready on both sides,
// flush and async reset. Tag and write-enable travel with the result.
module vector_exec_lane #(
  parameter int LANE_W = 16
) (
  input  logic [4:0]        i_op,
  input  logic [LANE_W-1:0] i_a,
  input  logic [LANE_W-1:0] i_b,
  output logic [LANE_W-1:0] o_res
);
  localparam int SH_W = $clog2(LANE_W);

  logic [SH_W-1:0]   w_sh;
  logic [LANE_W:0]   w_sum;
  logic [LANE_W-1:0] w_mul;

  assign w_sh  = i_b[SH_W-1:0];
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  // Truncated product: only the low half is ever forwarded.
  assign w_mul = i_a * i_b;

  always_comb begin
    o_res = '0;
    case (i_op)
      5'd0:    o_res = w_sum[LANE_W-1:0];
      5'd1:    o_res = i_a - i_b;
      5'd2:    o_res = i_a & i_b;
      5'd3:    o_res = i_a | i_b;
      5'd4:    o_res = i_a ^ i_b;
      5'd5:    o_res = i_a << w_sh;
      5'd6:    o_res = i_a >> w_sh;
      5'd7:    o_res = w_mul;
      5'd8:    o_res = w_sum[LANE_W] ? '1 : w_sum[LANE_W-1:0];
      5'd9:    o_res = (i_a > i_b) ? i_a : i_b;
      default: o_res = '0;
    endcase
  end
endmodule

module vector_exec_stage #(
  parameter int LANES   = 3,
  parameter int LANE_W  = 16,
  parameter int MUL_LAT = 3,
  parameter int TAG_W   = 5
) (
  input logic               clk,
  input logic               rst,
  vector_exec_stage_if.slave bus
);
  localparam int         CNT_W    = $clog2(MUL_LAT + 1);
  localparam logic [4:0] OP_MUL   = 5'd7;
  localparam logic [4:0] OP_LAST  = 5'd9;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t                         r_state, w_state_nx;
  logic [CNT_W-1:0]               r_cnt, w_cnt_nx;
  logic                           r_out_valid, w_ov_nx;
  logic [LANES-1:0][LANE_W-1:0]   r_result;
  logic [TAG_W-1:0]               r_tag_out;
  logic                           r_we_out;
  logic                           r_illegal;
  logic [LANES*LANE_W-1:0]        r_a, r_b;
  logic [TAG_W-1:0]               r_tag;
  logic                           r_we;

  logic                           w_busy, w_in_ready, w_accept, w_slot_free;
  logic                           w_load, w_cap, w_illegal;
  logic [4:0]                     w_op;
  logic [LANES-1:0][LANE_W-1:0]   w_a, w_b, w_res;

  assign w_busy      = (r_state == S_BUSY);
  assign w_slot_free = !r_out_valid || bus.out_ready;
  assign w_in_ready  = (r_state == S_IDLE) && w_slot_free && !bus.flush && !rst;
  assign w_accept    = bus.in_valid && w_in_ready;

  // While busy the lanes see the captured multiply operands, not the live bus.
  assign w_op      = w_busy ? OP_MUL : bus.alu_ctrl;
  assign w_a       = w_busy ? r_a : bus.src_a;
  assign w_b       = w_busy ? r_b : bus.src_b;
  assign w_illegal = (w_op > OP_LAST);

  vector_exec_lane #(.LANE_W(LANE_W)) u_lane [LANES-1:0] (
    .i_op  (w_op),
    .i_a   (w_a),
    .i_b   (w_b),
    .o_res (w_res)
  );

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_ov_nx    = r_out_valid;
    w_load     = 1'b0;
    w_cap      = 1'b0;
    if (bus.flush) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
      w_ov_nx    = 1'b0;
    end else begin
      if (r_out_valid && bus.out_ready) w_ov_nx = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.alu_ctrl == OP_MUL) begin
              w_state_nx = S_BUSY;
              w_cnt_nx   = CNT_INIT;
              w_cap      = 1'b1;
            end else begin
              w_load  = 1'b1;
              w_ov_nx = 1'b1;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt > CNT_W'(1)) begin
            w_cnt_nx = r_cnt - 1'b1;
          end else if (w_slot_free) begin
            // Product parks at cnt==1 until the output slot can take it.
            w_load     = 1'b1;
            w_ov_nx    = 1'b1;
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_out_valid <= w_ov_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result  <= '0;
      r_tag_out <= '0;
      r_we_out  <= 1'b0;
      r_illegal <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_tag     <= '0;
      r_we      <= 1'b0;
    end else begin
      if (w_cap) begin
        r_a   <= bus.src_a;
        r_b   <= bus.src_b;
        r_tag <= bus.tag_in;
        r_we  <= bus.we_in;
      end
      if (w_load) begin
        r_result  <= w_illegal ? '0 : w_res;
        r_tag_out <= w_busy ? r_tag : bus.tag_in;
        r_we_out  <= (w_busy ? r_we : bus.we_in) && !w_illegal;
        r_illegal <= w_illegal;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.result     = r_result;
  assign bus.tag_out    = r_tag_out;
  assign bus.we_out     = r_we_out;
  assign bus.illegal_op = r_illegal;
endmodule

// File: tb/tb_vector_exec_stage.sv
// Bench for vector_exec_stage: directed corner cases plus random traffic,
// with a scoreboard fed at acceptance and drained by an output monitor.
module tb_vector_exec_stage;
  localparam int LANES   = 3;
  localparam int LANE_W  = 16;
  localparam int MUL_LAT = 3;
  localparam int TAG_W   = 5;
  localparam int VW      = LANES * LANE_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vector_exec_stage_if #(.LANES(LANES), .LANE_W(LANE_W), .TAG_W(TAG_W)) bus ();

  vector_exec_stage #(.LANES(LANES), .LANE_W(LANE_W), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [VW-1:0]    res;
    logic [TAG_W-1:0] tag;
    logic             we;
    logic             ill;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lane arithmetic done on plain integers, independent of any bit-level structure.
  function automatic exp_t ref_model(input int op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                                     input logic [TAG_W-1:0] tag, input logic we);
    exp_t   e;
    longint la, lb, r, m;
    m     = longint'(1) << LANE_W;
    e.res = '0;
    e.tag = tag;
    e.ill = (op > 9);
    e.we  = we && (op <= 9);
    for (int i = 0; i < LANES; i++) begin
      la = a[i*LANE_W +: LANE_W];
      lb = b[i*LANE_W +: LANE_W];
      case (op)
        0:       r = (la + lb) % m;
        1:       r = (la - lb + m) % m;
        2:       r = la & lb;
        3:       r = la | lb;
        4:       r = la ^ lb;
        5:       r = (la << (lb % LANE_W)) % m;
        6:       r = la >> (lb % LANE_W);
        7:       r = (la * lb) % m;
        8:       r = (la + lb > m - 1) ? m - 1 : la + lb;
        9:       r = (la > lb) ? la : lb;
        default: r = 0;
      endcase
      e.res[i*LANE_W +: LANE_W] = r[LANE_W-1:0];
    end
    return e;
  endfunction

  task automatic issue(input int op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                       input logic [TAG_W-1:0] tag, input logic we);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus.alu_ctrl = op[4:0];
    bus.src_a    = a;
    bus.src_b    = b;
    bus.tag_in   = tag;
    bus.we_in    = we;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    chk("issue_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int lat;
    int op;
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst || bus.flush) begin
            sbq.delete();
          end else begin
            if (bus.out_valid && bus.out_ready) begin
              if (sbq.size() == 0) begin
                chk("sb_unexpected_output", 64'd1, 64'd0);
              end else begin
                e = sbq.pop_front();
                chk("sb_result", 64'({bus.result, bus.tag_out, bus.we_out, bus.illegal_op}), 64'(e));
              end
            end
            if (bus.in_valid && bus.in_ready)
              sbq.push_back(ref_model(int'(bus.alu_ctrl), bus.src_a, bus.src_b, bus.tag_in, bus.we_in));
          end
        end
      end
      begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
      end
    join_none

    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.alu_ctrl = '0;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.tag_in   = '0;
    bus.we_in    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_outputs", 64'({bus.result, bus.tag_out, bus.we_out, bus.illegal_op}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Lane-local wrap, no carry into the neighbour lane.
    issue(0, 48'h0001_FFFF_7FFF, 48'h0001_0001_0001, 5'd3, 1'b1);
    @(negedge clk);
    chk("add_valid", 64'(bus.out_valid), 64'd1);
    chk("add_result", 64'(bus.result), 64'h0002_0000_8000);

    issue(8, 48'hFFF0_0010_8000, 48'h0020_0010_8000, 5'd4, 1'b1);
    @(negedge clk);
    chk("adds_result", 64'(bus.result), 64'hFFFF_0020_FFFF);

    issue(6, 48'h00F0_00F0_00F0, 48'h0004_0004_0004, 5'd5, 1'b1);
    @(negedge clk);
    chk("srl_result", 64'(bus.result), 64'h000F_000F_000F);

    issue(7, 48'h0003_0100_FFFF, 48'h0005_0100_0002, 5'd9, 1'b1);
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.out_valid) lat = k;
      else chk("mul_busy_in_ready", 64'(bus.in_ready), 64'd0);
    end
    chk("mul_latency", 64'(lat), 64'(MUL_LAT));
    chk("mul_result", 64'(bus.result), 64'h000F_0000_FFFE);

    // Hold: stall downstream with a result sitting in the output slot.
    issue(0, 48'h1234_5678_9ABC, 48'h1111_1111_1111, 5'h11, 1'b1);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_result", 64'(bus.result), 64'h2345_6789_ABCD);
      chk("hold_tag", 64'(bus.tag_out), 64'h11);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.alu_ctrl  = 5'd0;
      bus.src_a     = VW'({$urandom(), $urandom()});
      bus.src_b     = VW'({$urandom(), $urandom()});
      bus.tag_in    = TAG_W'(i);
      bus.we_in     = 1'b1;
      @(negedge clk);
      chk("stream_accept", 64'(bus.in_ready), 64'd1);
      chk("stream_valid", 64'(bus.out_valid), 64'd1);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    chk("stream_drained", 64'(bus.out_valid), 64'd0);

    // Flush one cycle into a multiply.
    issue(7, 48'h0002_0002_0002, 48'h0003_0003_0003, 5'd6, 1'b1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_ready", 64'(bus.in_ready), 64'd1);
    for (int k = 0; k < MUL_LAT + 2; k++) begin
      @(negedge clk);
      chk("flush_no_valid", 64'(bus.out_valid), 64'd0);
    end
    issue(0, 48'h0000_0001_0002, 48'h0000_0001_0002, 5'd7, 1'b1);
    @(negedge clk);
    chk("flush_next_add", 64'({bus.out_valid, bus.result}), {15'd0, 1'b1, 48'h0000_0002_0004});

    // Async reset in the middle of a multiply.
    issue(7, 48'h0009_0009_0009, 48'h0009_0009_0009, 5'd8, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs",
        64'({bus.out_valid, bus.result, bus.tag_out, bus.we_out, bus.illegal_op}), 64'd0);
    chk("rst_async_in_ready", 64'(bus.in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < MUL_LAT + 2; k++) begin
      @(negedge clk);
      chk("rst_no_partial", 64'(bus.out_valid), 64'd0);
    end
    chk("rst_idle_ready", 64'(bus.in_ready), 64'd1);

    issue(31, 48'hABCD_1234_5678, 48'h1111_2222_3333, 5'h13, 1'b1);
    @(negedge clk);
    chk("illegal_flags", 64'({bus.illegal_op, bus.we_out}), 64'b10);
    chk("illegal_result", 64'(bus.result), 64'd0);
    chk("illegal_tag", 64'(bus.tag_out), 64'h13);

    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      op            = ($urandom_range(0, 19) == 0) ? int'($urandom_range(10, 31)) : int'($urandom_range(0, 9));
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.alu_ctrl  = op[4:0];
      bus.src_a     = VW'({$urandom(), $urandom()});
      bus.src_b     = VW'({$urandom(), $urandom()});
      bus.tag_in    = TAG_W'($urandom());
      bus.we_in     = $urandom_range(0, 1) == 1;
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.flush     = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 30 && sbq.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
